// File: rtl/fu_issue_if.sv
// Issue/writeback bundle between the reservation-station requesters and the shared
// multi-cycle functional-unit arbiter.
interface fu_issue_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 6
);
  logic                     flush;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*TAG_W-1:0] req_tag;
  logic [NUM_REQ-1:0]       grant;
  logic                     fu_start;
  logic [TAG_W-1:0]         fu_tag;
  logic                     busy;
  logic                     done_valid;
  logic [TAG_W-1:0]         done_tag;
  logic                     done_ready;

  modport master (
    output flush, req, req_tag, done_ready,
    input  grant, fu_start, fu_tag, busy, done_valid, done_tag
  );

  modport slave (
    input  flush, req, req_tag, done_ready,
    output grant, fu_start, fu_tag, busy, done_valid, done_tag
  );
endinterface

// File: rtl/fu_issue_arbiter.sv
// Round-robin issue arbiter for one non-pipelined multi-cycle FU: grants, counts the
// fixed latency, then holds the result tag on the CDB until accepted.
module fu_issue_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned LAT     = 8,
  parameter int unsigned CNT_W   = $clog2(LAT + 1)
) (
  input  logic      clk,
  input  logic      rst,
  fu_issue_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned SUM_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [PTR_W-1:0]   rr_ptr_q, ptr_d;

  logic [TAG_W-1:0]   tags [NUM_REQ];
  logic [SUM_W-1:0]   sum;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   nxt_ptr;
  logic               found;

  logic [NUM_REQ-1:0] grant_c;
  logic               start_c;
  logic [TAG_W-1:0]   ftag_c;
  logic               dv_c;

  // Unpack the flat per-requester tag bus.
  always_comb begin : tag_unpack
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      tags[i] = bus.req_tag[i*TAG_W +: TAG_W];
    end
  end

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin : rr_search
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr_q} + SUM_W'(i);
      if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
      if (!found && bus.req[sum[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = sum[PTR_W-1:0];
      end
    end
    nxt_ptr = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
  end

  // Next state and outputs; flush overrides everything and blocks both handshakes.
  always_comb begin : fsm_next
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    ptr_d   = rr_ptr_q;
    grant_c = '0;
    start_c = 1'b0;
    ftag_c  = '0;
    dv_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.flush && found && !rst) begin
          grant_c = NUM_REQ'(1) << winner;
          start_c = 1'b1;
          ftag_c  = tags[winner];
          tag_d   = tags[winner];
          ptr_d   = nxt_ptr;
          if (LAT == 1) begin
            state_d = WB;
          end else begin
            state_d = EXEC;
            cnt_d   = CNT_W'(LAT - 1);
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = WB;
      end
      WB: begin
        dv_c = !bus.flush;
        if (bus.done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : state_reg
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tag_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      rr_ptr_q <= ptr_d;
    end
  end

  assign bus.grant      = grant_c;
  assign bus.fu_start   = start_c;
  assign bus.fu_tag     = ftag_c;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done_valid = dv_c;
  assign bus.done_tag   = tag_q;

endmodule
